// File: rtl/display_pkg.sv
// Shared types and widths for the display read port.
package display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drp_state_t;

  localparam int PIXEL_W         = 24;
  localparam int WORD_W          = 32;
  localparam int BEAT_W          = 128;
  localparam int LINE_BEATS      = 2;
  localparam int LINE_ADDR_W     = 26;
  localparam int PIXELS_PER_BEAT = BEAT_W / WORD_W;
  localparam int RD_W            = PIXELS_PER_BEAT * PIXEL_W;

endpackage

// File: rtl/drp_pixel_pack.sv
// Combinational repack of one 128-bit beat (four 0,r,g,b words) into four
// 24-bit pixels. Build option: DRP_BYTESWAP_EN swaps r and b for BGR frame
// buffers. The top byte of each word is padding and is dropped.
module drp_pixel_pack
  import display_pkg::*;
(
  input  logic [BEAT_W-1:0] beat_data,
  output logic [RD_W-1:0]   pixels
);

  logic unused_pad_bits;

  // Slice each word into its pixel lane.
  always_comb begin
    pixels          = '0;
    unused_pad_bits = 1'b0;
    for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
`ifdef DRP_BYTESWAP_EN
      pixels[i*PIXEL_W +: PIXEL_W] = {beat_data[i*WORD_W      +: 8],
                                      beat_data[i*WORD_W + 8  +: 8],
                                      beat_data[i*WORD_W + 16 +: 8]};
`else
      pixels[i*PIXEL_W +: PIXEL_W] = beat_data[i*WORD_W +: PIXEL_W];
`endif
      unused_pad_bits = unused_pad_bits ^ (^beat_data[i*WORD_W + PIXEL_W +: 8]);
    end
  end

endmodule

// File: rtl/display_read_port.sv
// Back-door read port between the display controller and memMux.
// Accepts line requests, issues them to memMux with a bounded number of reads
// outstanding, and turns each returned beat into four pixels on RD/RDready.
// Build option: DRP_BYTESWAP_EN (handled inside drp_pixel_pack).
module display_read_port
  import display_pkg::*;
#(
  parameter int MAX_OUT = 8
) (
  input  logic                   clock,
  input  logic                   resetB,
  input  logic                   dispReq,
  input  logic [LINE_ADDR_W-1:0] dispAddr,
  output logic                   dispAck,
  output logic [RD_W-1:0]        RD,
  output logic                   RDready,
  output logic                   memReq,
  output logic [LINE_ADDR_W-1:0] memAddr,
  input  logic                   memGrant,
  input  logic [BEAT_W-1:0]      memRdData,
  input  logic                   memRdValid,
  output logic                   busy,
  output logic                   orphan
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  drp_state_t             state_q, state_d;
  logic [LINE_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic                   beat_q, beat_d;
  logic [RD_W-1:0]        rd_q, rd_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   orphan_q, orphan_d;

  logic [RD_W-1:0] packed_pixels;
  logic            disp_ack;
  logic            have_out;
  logic            beat_in;
  logic            grant_take;
  logic            line_done;

  drp_pixel_pack u_pack (
    .beat_data (memRdData),
    .pixels    (packed_pixels)
  );

  // Credit check is combinational so the requester can step its address next cycle;
  // gating with resetB keeps the ack quiet while the block is held in reset.
  assign disp_ack   = (state_q == IDLE) && dispReq && (out_cnt_q < MAX_OUT_C) && resetB;
  assign have_out   = (out_cnt_q != '0);
  assign beat_in    = memRdValid && have_out;
  assign grant_take = (state_q == REQ) && memGrant;
  assign line_done  = beat_in && beat_q;

  // Next-state for request FSM, credit counter, beat tracking and data capture.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    out_cnt_d  = out_cnt_q;
    beat_d     = beat_q;
    rd_d       = rd_q;
    rd_ready_d = 1'b0;
    orphan_d   = orphan_q;

    case (state_q)
      IDLE: begin
        if (disp_ack) begin
          state_d    = REQ;
          mem_addr_d = dispAddr;
        end
      end
      REQ: begin
        if (memGrant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (beat_in) begin
      beat_d     = ~beat_q;
      rd_d       = packed_pixels;
      rd_ready_d = 1'b1;
    end

    // Data with nothing outstanding is dropped and flagged until reset.
    if (memRdValid && !have_out) orphan_d = 1'b1;

    // A grant and a line completion in the same cycle cancel out.
    case ({grant_take, line_done})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      out_cnt_q  <= '0;
      beat_q     <= 1'b0;
      rd_q       <= '0;
      rd_ready_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      out_cnt_q  <= out_cnt_d;
      beat_q     <= beat_d;
      rd_q       <= rd_d;
      rd_ready_q <= rd_ready_d;
      orphan_q   <= orphan_d;
    end
  end

  assign dispAck = disp_ack;
  assign memReq  = (state_q == REQ);
  assign memAddr = mem_addr_q;
  assign RD      = rd_q;
  assign RDready = rd_ready_q;
  assign busy    = (state_q == REQ) || have_out;
  assign orphan  = orphan_q;

endmodule

// File: tb/tb_display_read_port.sv
// Bench for display_read_port: pixel beats go through a queue of expected RD
// words, request/credit behaviour is checked inline by each scenario task.
module tb_display_read_port;

  logic         clock = 1'b0;
  logic         resetB;
  logic         dispReq;
  logic [25:0]  dispAddr;
  logic         dispAck;
  logic [95:0]  RD;
  logic         RDready;
  logic         memReq;
  logic [25:0]  memAddr;
  logic         memGrant;
  logic [127:0] memRdData;
  logic         memRdValid;
  logic         busy;
  logic         orphan;

  int vectors    = 0;
  int miscompares = 0;
  logic [95:0] exp_q[$];

  always #5 clock = ~clock;

  display_read_port #(.MAX_OUT(8)) dut (
    .clock      (clock),
    .resetB     (resetB),
    .dispReq    (dispReq),
    .dispAddr   (dispAddr),
    .dispAck    (dispAck),
    .RD         (RD),
    .RDready    (RDready),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memGrant   (memGrant),
    .memRdData  (memRdData),
    .memRdValid (memRdValid),
    .busy       (busy),
    .orphan     (orphan)
  );

  function automatic logic [23:0] pix(input logic [31:0] w);
`ifdef DRP_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16]};
`else
    return w[23:0];
`endif
  endfunction

  function automatic logic [95:0] pack_beat(input logic [127:0] d);
    return {pix(d[127:96]), pix(d[95:64]), pix(d[63:32]), pix(d[31:0])};
  endfunction

  function automatic logic [127:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every RDready pops one expected pixel word.
  always @(negedge clock) begin
    if (RDready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: RDready=1 RD=%h, required no output", RD);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if (RD !== e) begin
          miscompares++;
          $display("FAIL rd_data: RD=%h required %h", RD, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input bit expect_out);
    memRdData  = d;
    memRdValid = 1'b1;
    if (expect_out) exp_q.push_back(pack_beat(d));
    tick();
    memRdValid = 1'b0;
  endtask

  task automatic request_line(input logic [25:0] a);
    dispReq  = 1'b1;
    dispAddr = a;
    tick();
    dispReq  = 1'b0;
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d beats still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetB     = 1'b0;
    dispReq    = 1'b1;
    dispAddr   = 26'h2AAAAAA;
    memGrant   = 1'b0;
    memRdData  = '0;
    memRdValid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({dispAck, RD, RDready, memReq, memAddr, busy, orphan} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b RD=%h rdy=%b req=%b addr=%h busy=%b orphan=%b, required all 0",
               dispAck, RD, RDready, memReq, memAddr, busy, orphan);
    end
    dispReq = 1'b0;
    resetB  = 1'b1;
    tick();
  endtask

  task automatic test_single_line();
    dispReq  = 1'b1;
    dispAddr = 26'h1000000;
    @(negedge clock);
    vectors++;
    if (dispAck !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: dispAck=%b required 1", dispAck);
    end
    tick();
    dispReq  = 1'b0;
    dispAddr = 26'h0;
    @(negedge clock);
    vectors++;
    if ({memReq, memAddr, dispAck} !== {1'b1, 26'h1000000, 1'b0}) begin
      miscompares++;
      $display("FAIL single_req: memReq=%b memAddr=%h dispAck=%b required 1 1000000 0", memReq, memAddr, dispAck);
    end
    tick();
    memGrant = 1'b1;
    @(negedge clock);
    vectors++;
    if (memReq !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req_hold: memReq=%b required 1", memReq);
    end
    tick();
    memGrant = 1'b0;
    @(negedge clock);
    vectors++;
    if ({memReq, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_granted: memReq=%b busy=%b required 0 1", memReq, busy);
    end
    tick();
    send_beat({4{32'hAA112233}}, 1'b1);
    send_beat({32'hAA445566, 32'hAA778899, 32'hAABBCCDD, 32'hAA112233}, 1'b1);
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_fall: busy=%b required 0", busy);
    end
    tick();
    check_queue_empty("single_rd_count");
  endtask

  task automatic test_credit();
    int acks = 0;
    dispReq  = 1'b1;
    dispAddr = 26'h0000100;
    memGrant = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (dispAck === 1'b1) acks++;
      tick();
    end
    vectors++;
    if (acks != 8) begin
      miscompares++;
      $display("FAIL credit_acks: %0d acks required 8", acks);
    end
    @(negedge clock);
    vectors++;
    if ({dispAck, memReq, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL credit_stall: ack=%b req=%b busy=%b required 0 0 1", dispAck, memReq, busy);
    end
    tick();
    send_beat(rand_beat(), 1'b1);
    @(negedge clock);
    vectors++;
    if (dispAck !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_half_line: dispAck=%b required 0", dispAck);
    end
    tick();
    send_beat(rand_beat(), 1'b1);
    @(negedge clock);
    vectors++;
    if (dispAck !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_ninth_ack: dispAck=%b required 1", dispAck);
    end
    tick();
    dispReq = 1'b0;
    tick();
    memGrant = 1'b0;
    vectors++;
    if (dut.out_cnt_q !== 4'd8) begin
      miscompares++;
      $display("FAIL credit_refill: outCnt=%0d required 8", dut.out_cnt_q);
    end
    for (int i = 0; i < 16; i++) send_beat(rand_beat(), 1'b1);
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_drain: busy=%b required 0", busy);
    end
    tick();
    check_queue_empty("credit_rd_count");
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) request_line(26'h0000200 + 26'(i));
    send_beat(rand_beat(), 1'b1);
    dispReq  = 1'b1;
    dispAddr = 26'h0000300;
    tick();
    dispReq  = 1'b0;
    memGrant = 1'b1;
    send_beat(rand_beat(), 1'b1);
    memGrant = 1'b0;
    vectors++;
    if (dut.out_cnt_q !== 4'd3 || memReq !== 1'b0) begin
      miscompares++;
      $display("FAIL simultaneous: outCnt=%0d memReq=%b required 3 0", dut.out_cnt_q, memReq);
    end
    for (int i = 0; i < 6; i++) send_beat(rand_beat(), 1'b1);
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL simultaneous_drain: busy=%b required 0", busy);
    end
    tick();
    check_queue_empty("simultaneous_rd_count");
  endtask

  task automatic test_orphan();
    vectors++;
    if (orphan !== 1'b0) begin
      miscompares++;
      $display("FAIL orphan_pre: orphan=%b required 0", orphan);
    end
    send_beat(rand_beat(), 1'b0);
    @(negedge clock);
    vectors++;
    if ({RDready, orphan} !== 2'b01) begin
      miscompares++;
      $display("FAIL orphan_set: RDready=%b orphan=%b required 0 1", RDready, orphan);
    end
    tick();
    request_line(26'h0000400);
    send_beat(rand_beat(), 1'b1);
    send_beat(rand_beat(), 1'b1);
    repeat (3) tick();
    vectors++;
    if ({orphan, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL orphan_sticky: orphan=%b busy=%b required 1 0", orphan, busy);
    end
    check_queue_empty("orphan_line_after");
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) request_line(26'h0000500 + 26'(i));
    send_beat(rand_beat(), 1'b1);
    dispReq  = 1'b1;
    dispAddr = 26'h0000600;
    tick();
    tick();
    resetB = 1'b0;
    #1;
    vectors++;
    if ({dispAck, RD, RDready, memReq, memAddr, busy, orphan} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: ack=%b RD=%h rdy=%b req=%b addr=%h busy=%b orphan=%b, required all 0",
               dispAck, RD, RDready, memReq, memAddr, busy, orphan);
    end
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({dispAck, memReq, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_hold: ack=%b req=%b busy=%b required 0 0 0", dispAck, memReq, busy);
    end
    dispReq = 1'b0;
    resetB  = 1'b1;
    tick();
    send_beat(rand_beat(), 1'b0);
    @(negedge clock);
    vectors++;
    if ({RDready, orphan} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_mid_orphan: RDready=%b orphan=%b required 0 1", RDready, orphan);
    end
    tick();
    dispReq  = 1'b1;
    dispAddr = 26'h0ABCDEF;
    @(negedge clock);
    vectors++;
    if (dispAck !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ack: dispAck=%b required 1", dispAck);
    end
    tick();
    dispReq  = 1'b0;
    memGrant = 1'b1;
    @(negedge clock);
    vectors++;
    if ({memReq, memAddr} !== {1'b1, 26'h0ABCDEF}) begin
      miscompares++;
      $display("FAIL reset_mid_req: memReq=%b memAddr=%h required 1 0abcdef", memReq, memAddr);
    end
    tick();
    memGrant = 1'b0;
    send_beat(rand_beat(), 1'b1);
    send_beat(rand_beat(), 1'b1);
    tick();
    check_queue_empty("reset_mid_line");
  endtask

  task automatic test_byteswap();
    logic [23:0] want;
`ifdef DRP_BYTESWAP_EN
    want = 24'h332211;
`else
    want = 24'h112233;
`endif
    request_line(26'h0000700);
    send_beat({32'h00445566, 32'h00778899, 32'h00AABBCC, 32'h00112233}, 1'b1);
    @(negedge clock);
    vectors++;
    if (RD[23:0] !== want) begin
      miscompares++;
      $display("FAIL byteswap_pixel0: RD[23:0]=%h required %h", RD[23:0], want);
    end
    tick();
    send_beat(rand_beat(), 1'b1);
    tick();
    check_queue_empty("byteswap_line");
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_credit();
    test_simultaneous();
    test_orphan();
    test_reset_midflight();
    test_byteswap();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
